plru_tree_unit: RTL and testbench
=================================

Name: plru_tree_unit

Overview:
- Parametrised tree pseudo-LRU replacement engine for an N-way set-associative cache.
- Holds WAYS-1 tree bits per set and applies CPU-side and bus-side (snoop/fill) touch updates internally, with same-cycle merging.
- Returns a registered victim way per lookup.
- Clears all sets with a hardware sweep after reset; no initial-block dependence.

Parameters:
- WAYS, 4, associativity; power of 2, 2..16. TREE_BITS = WAYS-1 and WAY_BITS = log2(WAYS) are derived.
- SET_BITS, 4, set index width; depth = 2**SET_BITS sets.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- init_busy  out  1  high while the clear sweep runs
- lkp_valid  in  1  victim lookup request
- lkp_set  in  SET_BITS  set to look up
- victim_valid  out  1  pulses one cycle after an accepted lookup
- victim_way  out  WAY_BITS  selected victim way
- victim_tree  out  TREE_BITS  tree bits used to select the victim
- cpu_touch_en  in  1  CPU access hit/fill
- cpu_touch_set  in  SET_BITS  set of the CPU access
- cpu_touch_way  in  WAY_BITS  way accessed by the CPU
- bus_touch_en  in  1  bus-side access
- bus_touch_set  in  SET_BITS  set of the bus access
- bus_touch_way  in  WAY_BITS  way accessed on the bus

Behaviour:
- Tree encoding: heap nodes 1..WAYS-1; node n is stored at bit n-1; children are 2n and 2n+1; a leaf node L maps to way L-WAYS.
- Victim walk: start at node 1. Bit 0 goes left (2n), bit 1 goes right (2n+1). Repeat for WAY_BITS levels.
- Touch of way w: each node on the path to w is set to point away from w. Going left to reach w sets the node bit to 1; going right sets it to 0. Nodes off the path are unchanged.
- Storage: register array of 2**SET_BITS x TREE_BITS. Two writes per cycle are supported when the two touches target different sets.
- Same-cycle touches to the same set: result = touch(touch(old, cpu_way), bus_way). The bus touch has the final say on shared nodes.
- Lookup: registered, 1-cycle latency. It reads write-first, so the victim reflects touches presented in the same cycle to the same set. victim_tree shows the post-touch bits.
- Back-to-back lookups are accepted every cycle. There is no backpressure.
- FSM states:
  - RESET: entered while rst_n=0.
  - INIT: on the first cycle with rst_n=1, a counter clears sets 0..2**SET_BITS-1, one per cycle. After writing the last set, go to READY.
  - READY: normal operation.
- During RESET and INIT:
  - init_busy=1.
  - Touches are dropped.
  - Lookups are ignored; victim_valid=0.
- init_busy falls on the cycle READY is entered. Requests are accepted from that cycle.
- Reset values: init_busy=1, victim_valid=0, victim_way=0, victim_tree=0.
- Reset asserted mid-sweep or mid-operation returns to RESET. The sweep restarts from set 0 after release.
- Set index wrap: the init counter covers exactly 2**SET_BITS sets, with no over-count.
- WAYS=2 degenerates to a single bit per set. The same rules apply.

Test Plan:
- Reset release, WAYS=4, SET_BITS=4 -> init_busy high exactly 16 cycles. Lookup on set 3 in the first READY cycle -> next cycle victim_valid=1, victim_way=0, victim_tree=3'b000.
- Touch set 3 way 0, then look up set 3 -> victim_tree=3'b011, victim_way=2.
- From init, touch set 3 way 0 then way 2 (separate cycles), then look up -> victim_tree=3'b110, victim_way=1. Set 4 is unaffected: a lookup returns way 0.
- Same cycle from init: cpu_touch set 5 way 1 + bus_touch set 5 way 3 + lkp set 5 -> victim_tree=3'b000, victim_way=0 (write-first, bus last). Repeat with the two touches on sets 5 and 6 -> both sets updated, to 3'b001 and 3'b100 respectively.
- Touch/lookup during init -> dropped. After READY, set 0 lookup -> way 0 and victim_valid never pulsed during INIT.
- rst_n low for 1 cycle at sweep cycle 5 -> init_busy stays 1, sweep restarts, 16 more busy cycles. Previously touched sets read 3'b000 afterward.

Source files
------------

// File: rtl/plru_tree_unit_if.sv
// Request/response bundle for the tree pseudo-LRU engine: lookups, CPU and bus touches,
// victim result and init status.
interface plru_tree_unit_if #(
    parameter int WAYS     = 4,
    parameter int SET_BITS = 4
);
    localparam int TREE_BITS = WAYS - 1;
    localparam int WAY_BITS  = $clog2(WAYS);

    logic                 init_busy;
    logic                 lkp_valid;
    logic [SET_BITS-1:0]  lkp_set;
    logic                 victim_valid;
    logic [WAY_BITS-1:0]  victim_way;
    logic [TREE_BITS-1:0] victim_tree;
    logic                 cpu_touch_en;
    logic [SET_BITS-1:0]  cpu_touch_set;
    logic [WAY_BITS-1:0]  cpu_touch_way;
    logic                 bus_touch_en;
    logic [SET_BITS-1:0]  bus_touch_set;
    logic [WAY_BITS-1:0]  bus_touch_way;

    modport master (
        input  init_busy, victim_valid, victim_way, victim_tree,
        output lkp_valid, lkp_set,
        output cpu_touch_en, cpu_touch_set, cpu_touch_way,
        output bus_touch_en, bus_touch_set, bus_touch_way
    );

    modport slave (
        output init_busy, victim_valid, victim_way, victim_tree,
        input  lkp_valid, lkp_set,
        input  cpu_touch_en, cpu_touch_set, cpu_touch_way,
        input  bus_touch_en, bus_touch_set, bus_touch_way
    );
endinterface

// File: rtl/plru_tree_unit.sv
// Tree pseudo-LRU replacement engine: per-set heap of WAYS-1 bits, merged CPU/bus touches,
// write-first registered victim lookup, and a post-reset clear sweep.
//
// state    | meaning
// ST_RESET | held in reset; first released cycle clears set 0
// ST_INIT  | clear sweep, one set per cycle, through the last set
// ST_READY | normal operation, touches and lookups accepted
module plru_tree_unit #(
    parameter int WAYS     = 4,
    parameter int SET_BITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    plru_tree_unit_if.slave  pif
);
    localparam int TREE_BITS = WAYS - 1;
    localparam int WAY_BITS  = $clog2(WAYS);
    localparam int SETS      = 2 ** SET_BITS;

    typedef logic [TREE_BITS-1:0] tree_t;
    typedef logic [WAY_BITS-1:0]  way_t;
    typedef logic [SET_BITS-1:0]  set_t;

    typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_READY} state_t;

    state_t state_q, state_d;
    set_t   init_cnt_q;
    tree_t  tree_mem [SETS];
    logic   ready;
    logic   same_set;
    tree_t  cpu_new, bus_new, lkp_tree;

    // The node mask is one bit wider than the tree so heap node n lands on bit n-1
    // after dropping bit 0.
    function automatic tree_t touch(input tree_t t, input way_t w);
        tree_t                r;
        way_t                 ws;
        logic [WAY_BITS:0]    node;
        logic [TREE_BITS:0]   oh;
        logic                 dir;
        r    = t;
        ws   = w;
        node = (WAY_BITS+1)'(1);
        for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
            dir  = ws[WAY_BITS-1];
            oh   = (TREE_BITS+1)'(1) << node;
            r    = dir ? (r & ~oh[TREE_BITS:1]) : (r | oh[TREE_BITS:1]);
            node = {node[WAY_BITS-1:0], dir};
            ws   = ws << 1;
        end
        return r;
    endfunction

    function automatic way_t walk(input tree_t t);
        logic [WAY_BITS:0]    node;
        logic [TREE_BITS:0]   oh;
        logic                 dir;
        node = (WAY_BITS+1)'(1);
        for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
            oh   = (TREE_BITS+1)'(1) << node;
            dir  = |(t & oh[TREE_BITS:1]);
            node = {node[WAY_BITS-1:0], dir};
        end
        return node[WAY_BITS-1:0];
    endfunction

    assign ready         = (state_q == ST_READY);
    assign pif.init_busy = !ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RESET;
            init_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (!ready) init_cnt_q <= init_cnt_q + set_t'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RESET, ST_INIT: state_d = (init_cnt_q == set_t'(SETS - 1)) ? ST_READY : ST_INIT;
            ST_READY:          state_d = ST_READY;
            default:           state_d = ST_RESET;
        endcase
    end

    // Bus touch is applied on top of the CPU touch when both hit the same set.
    always_comb begin
        same_set = pif.cpu_touch_en && pif.bus_touch_en && (pif.cpu_touch_set == pif.bus_touch_set);
        cpu_new  = touch(tree_mem[pif.cpu_touch_set], pif.cpu_touch_way);
        bus_new  = touch(same_set ? cpu_new : tree_mem[pif.bus_touch_set], pif.bus_touch_way);
        lkp_tree = tree_mem[pif.lkp_set];
        if (pif.cpu_touch_en && (pif.cpu_touch_set == pif.lkp_set))
            lkp_tree = touch(lkp_tree, pif.cpu_touch_way);
        if (pif.bus_touch_en && (pif.bus_touch_set == pif.lkp_set))
            lkp_tree = touch(lkp_tree, pif.bus_touch_way);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (!ready) begin
                tree_mem[init_cnt_q] <= '0;
            end else begin
                if (pif.cpu_touch_en && !same_set) tree_mem[pif.cpu_touch_set] <= cpu_new;
                if (pif.bus_touch_en)              tree_mem[pif.bus_touch_set] <= bus_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pif.victim_valid <= 1'b0;
            pif.victim_way   <= '0;
            pif.victim_tree  <= '0;
        end else begin
            pif.victim_valid <= ready && pif.lkp_valid;
            if (ready && pif.lkp_valid) begin
                pif.victim_tree <= lkp_tree;
                pif.victim_way  <= walk(lkp_tree);
            end
        end
    end
endmodule

// File: tb/tb_plru_tree_unit.sv
// Self-checking bench for plru_tree_unit: heap-arithmetic reference model compared every
// cycle, plus hand-computed directed cases and randomized touch/lookup traffic.
module tb_plru_tree_unit;
    localparam int WAYS     = 4;
    localparam int SET_BITS = 4;
    localparam int TB       = WAYS - 1;
    localparam int WB       = $clog2(WAYS);
    localparam int SETS     = 2 ** SET_BITS;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    bit   started = 0;

    plru_tree_unit_if #(.WAYS(WAYS), .SET_BITS(SET_BITS)) pif();

    plru_tree_unit #(.WAYS(WAYS), .SET_BITS(SET_BITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pif   (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: path from leaf (way+WAYS) up to the root, each parent points away.
    logic [TB-1:0] m_tree [SETS];
    bit            m_ready = 0;
    int            m_sweep = 0;
    bit            exp_valid = 0;
    logic [TB-1:0] exp_tree;
    int            exp_way;
    logic [TB-1:0] m_t;

    function automatic logic [TB-1:0] m_touch(input logic [TB-1:0] t, input int w);
        int n = w + WAYS;
        while (n > 1) begin
            t[n/2 - 1] = (n % 2 == 0);
            n = n / 2;
        end
        return t;
    endfunction

    function automatic int m_victim(input logic [TB-1:0] t);
        int n = 1;
        while (n < WAYS) n = 2 * n + int'(t[n-1]);
        return n - WAYS;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ready   = 0;
            m_sweep   = 0;
            exp_valid = 0;
        end else if (!m_ready) begin
            m_tree[m_sweep] = '0;
            m_sweep++;
            if (m_sweep == SETS) m_ready = 1;
            exp_valid = 0;
        end else begin
            exp_valid = pif.lkp_valid;
            if (pif.lkp_valid) begin
                m_t = m_tree[pif.lkp_set];
                if (pif.cpu_touch_en && pif.cpu_touch_set == pif.lkp_set) m_t = m_touch(m_t, int'(pif.cpu_touch_way));
                if (pif.bus_touch_en && pif.bus_touch_set == pif.lkp_set) m_t = m_touch(m_t, int'(pif.bus_touch_way));
                exp_tree = m_t;
                exp_way  = m_victim(m_t);
            end
            if (pif.cpu_touch_en)
                m_tree[pif.cpu_touch_set] = m_touch(m_tree[pif.cpu_touch_set], int'(pif.cpu_touch_way));
            if (pif.bus_touch_en)
                m_tree[pif.bus_touch_set] = m_touch(m_tree[pif.bus_touch_set], int'(pif.bus_touch_way));
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_busy", pif.init_busy, !m_ready);
            chk("model_valid", pif.victim_valid, exp_valid);
            if (exp_valid) begin
                chk("model_way", pif.victim_way, exp_way);
                chk("model_tree", pif.victim_tree, exp_tree);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle();
        pif.lkp_valid    = 0;
        pif.cpu_touch_en = 0;
        pif.bus_touch_en = 0;
    endtask

    task automatic cpu_touch(input logic [SET_BITS-1:0] s, input logic [WB-1:0] w);
        pif.cpu_touch_en  = 1;
        pif.cpu_touch_set = s;
        pif.cpu_touch_way = w;
        cyc();
        idle();
    endtask

    task automatic lookup(input string name, input logic [SET_BITS-1:0] s,
                          input int e_way, input logic [TB-1:0] e_tree);
        pif.lkp_valid = 1;
        pif.lkp_set   = s;
        cyc();
        idle();
        chk({name, "_valid"}, pif.victim_valid, 1);
        chk({name, "_way"}, pif.victim_way, e_way);
        chk({name, "_tree"}, pif.victim_tree, e_tree);
    endtask

    task automatic count_busy(input string name, input bit poke);
        int n = 0;
        while (pif.init_busy === 1'b1 && n < 100) begin
            chk({name, "_no_valid"}, pif.victim_valid, 0);
            if (poke) begin
                pif.cpu_touch_en  = 1; pif.cpu_touch_set = 0; pif.cpu_touch_way = 0;
                pif.lkp_valid     = 1; pif.lkp_set       = 0;
            end
            n++;
            cyc();
        end
        idle();
        chk({name, "_busy_cycles"}, n, SETS);
    endtask

    initial begin
        rst_n = 0;
        pif.lkp_set = 0; pif.cpu_touch_set = 0; pif.cpu_touch_way = 0;
        pif.bus_touch_set = 0; pif.bus_touch_way = 0;
        idle();
        repeat (3) cyc();
        started = 1;
        chk("rst_busy", pif.init_busy, 1);
        chk("rst_valid", pif.victim_valid, 0);
        chk("rst_way", pif.victim_way, 0);
        chk("rst_tree", pif.victim_tree, 0);

        rst_n = 1;
        count_busy("init", 1);
        lookup("first_ready", 3, 0, 3'b000);
        lookup("init_drop", 0, 0, 3'b000);

        cpu_touch(3, 0);
        lookup("touch_w0", 3, 2, 3'b011);
        cpu_touch(3, 2);
        lookup("touch_w2", 3, 1, 3'b110);
        lookup("set4_clean", 4, 0, 3'b000);

        pif.cpu_touch_en = 1; pif.cpu_touch_set = 5; pif.cpu_touch_way = 1;
        pif.bus_touch_en = 1; pif.bus_touch_set = 5; pif.bus_touch_way = 3;
        lookup("merge_same", 5, 0, 3'b000);
        pif.cpu_touch_en = 1; pif.cpu_touch_set = 5; pif.cpu_touch_way = 1;
        pif.bus_touch_en = 1; pif.bus_touch_set = 6; pif.bus_touch_way = 2;
        cyc();
        idle();
        lookup("dual_set5", 5, 2, 3'b001);
        lookup("dual_set6", 6, 0, 3'b100);

        for (int i = 0; i < 1500; i++) begin
            bit narrow = ($urandom % 2) == 1;
            pif.cpu_touch_en  = ($urandom % 3) != 0;
            pif.bus_touch_en  = ($urandom % 3) != 0;
            pif.lkp_valid     = ($urandom % 2) == 1;
            pif.cpu_touch_set = SET_BITS'(narrow ? $urandom_range(0, 1) : $urandom_range(0, SETS - 1));
            pif.bus_touch_set = SET_BITS'(narrow ? $urandom_range(0, 1) : $urandom_range(0, SETS - 1));
            pif.lkp_set       = SET_BITS'(narrow ? $urandom_range(0, 1) : $urandom_range(0, SETS - 1));
            pif.cpu_touch_way = WB'($urandom_range(0, WAYS - 1));
            pif.bus_touch_way = WB'($urandom_range(0, WAYS - 1));
            cyc();
        end
        idle();

        cpu_touch(3, 0);
        cpu_touch(5, 1);
        rst_n = 0;
        cyc();
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            chk("sweep_busy", pif.init_busy, 1);
            cyc();
        end
        rst_n = 0;
        cyc();
        chk("midreset_busy", pif.init_busy, 1);
        rst_n = 1;
        count_busy("restart", 0);
        lookup("cleared_set3", 3, 0, 3'b000);
        lookup("cleared_set5", 5, 0, 3'b000);
        lookup("cleared_set6", 6, 0, 3'b000);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
